// File: rtl/sar_adc_mc_if.sv
// Control/status bundle of the multi-channel SAR ADC (request, abort, result).
// The ovr result flag exists only when SAR_ADC_OVR_EN is defined.
interface sar_adc_mc_if #(
    parameter int BITS     = 8,
    parameter int CHANNELS = 4
);
    localparam int CW = (CHANNELS > 32'sd1) ? $clog2(CHANNELS) : 32'sd1;

    logic            start;
    logic [CW-1:0]   ch_sel;
    logic            abort;
    logic            busy;
    logic            valid;
    logic [BITS-1:0] code;
    logic [CW-1:0]   ch_out;
`ifdef SAR_ADC_OVR_EN
    logic            ovr;

    modport master (output start, ch_sel, abort,
                    input  busy, valid, code, ch_out, ovr);
    modport slave  (input  start, ch_sel, abort,
                    output busy, valid, code, ch_out, ovr);
`else
    modport master (output start, ch_sel, abort,
                    input  busy, valid, code, ch_out);
    modport slave  (input  start, ch_sel, abort,
                    output busy, valid, code, ch_out);
`endif
endinterface

// File: rtl/sar_adc_mc.sv
// Behavioural multi-channel successive-approximation ADC: sample, BITS binary-search steps, result.
// Define SAR_ADC_OVR_EN to add the out-of-range flag ovr, registered alongside code.
module sar_adc_mc #(
    parameter int  BITS     = 8,
    parameter int  CHANNELS = 4,
    parameter real VREF     = 1.0
) (
    input  logic        clk,
    input  logic        rst,
    input  real         vin [CHANNELS],
    output real         dac_level,
    sar_adc_mc_if.slave bus
);
    localparam int              CW       = (CHANNELS > 32'sd1) ? $clog2(CHANNELS) : 32'sd1;
    localparam int              IW       = $clog2(BITS);
    localparam real             LSB      = VREF / real'(32'd1 << BITS);
    localparam logic [CW:0]     CH_LIMIT = CHANNELS[CW:0];
    localparam logic [BITS-1:0] MSB_ONLY = {1'b1, {(BITS-1){1'b0}}};
    localparam logic [BITS-1:0] ONE_B    = {{(BITS-1){1'b0}}, 1'b1};
    localparam logic [IW-1:0]   IDX_ZERO = {IW{1'b0}};
    localparam logic [IW-1:0]   IDX_ONE  = IW'(32'd1);
    localparam logic [IW-1:0]   IDX_MSB  = IW'(BITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SAMPLE  = 2'd1,
        ST_CONVERT = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    state_e          state_r, state_nx_s;
    logic [CW-1:0]   ch_r;
    logic [BITS-1:0] trial_r, trial_nx_s, bit_s;
    logic [IW-1:0]   idx_r;
    real             held_r, held_nx_s;
    logic            ch_ok_s, accept_s, sample_s, step_s, finish_s, keep_s;
    logic            busy_r, valid_r;
    logic [BITS-1:0] code_r;
    logic [CW-1:0]   ch_out_r;
    real             dac_r;
`ifdef SAR_ADC_OVR_EN
    logic            ovr_smp_s, ovr_smp_r, ovr_r;
`endif

    assign ch_ok_s = ({1'b0, bus.ch_sel} < CH_LIMIT);
    assign bit_s   = ONE_B << idx_r;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic; abort outranks everything while a conversion is in flight
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (bus.start && ch_ok_s) state_nx_s = ST_SAMPLE;
                else                      state_nx_s = ST_IDLE;
            end
            ST_SAMPLE: begin
                if (bus.abort) state_nx_s = ST_IDLE;
                else           state_nx_s = ST_CONVERT;
            end
            ST_CONVERT: begin
                if (bus.abort)                state_nx_s = ST_IDLE;
                else if (idx_r == IDX_ZERO)   state_nx_s = ST_DONE;
                else                          state_nx_s = ST_CONVERT;
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Datapath strobes and next trial word; a failed compare clears the bit under test
    always_comb begin
        accept_s   = 1'b0;
        sample_s   = 1'b0;
        step_s     = 1'b0;
        finish_s   = 1'b0;
        held_nx_s  = held_r;
        keep_s     = (held_r >= real'(trial_r) * LSB);
        trial_nx_s = trial_r;
`ifdef SAR_ADC_OVR_EN
        ovr_smp_s  = 1'b0;
`endif
        case (state_r)
            ST_IDLE, ST_DONE: begin
                accept_s = bus.start && ch_ok_s;
            end
            ST_SAMPLE: begin
                sample_s   = !bus.abort;
                trial_nx_s = MSB_ONLY;
                if (vin[ch_r] < 0.0)       held_nx_s = 0.0;
                else if (vin[ch_r] > VREF) held_nx_s = VREF;
                else                       held_nx_s = vin[ch_r];
`ifdef SAR_ADC_OVR_EN
                ovr_smp_s = (vin[ch_r] < 0.0) || (vin[ch_r] > VREF);
`endif
            end
            ST_CONVERT: begin
                step_s     = !bus.abort;
                finish_s   = !bus.abort && (idx_r == IDX_ZERO);
                trial_nx_s = (keep_s ? trial_r : (trial_r & ~bit_s)) | (bit_s >> 1);
            end
            default: begin
                accept_s = 1'b0;
            end
        endcase
    end

    // Conversion registers and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ch_r     <= {CW{1'b0}};
            held_r   <= 0.0;
            trial_r  <= {BITS{1'b0}};
            idx_r    <= IDX_ZERO;
            code_r   <= {BITS{1'b0}};
            ch_out_r <= {CW{1'b0}};
            busy_r   <= 1'b0;
            valid_r  <= 1'b0;
            dac_r    <= 0.0;
`ifdef SAR_ADC_OVR_EN
            ovr_smp_r <= 1'b0;
            ovr_r     <= 1'b0;
`endif
        end else begin
            if (accept_s) ch_r <= bus.ch_sel;
            if (sample_s) begin
                held_r  <= held_nx_s;
                trial_r <= trial_nx_s;
                idx_r   <= IDX_MSB;
`ifdef SAR_ADC_OVR_EN
                ovr_smp_r <= ovr_smp_s;
`endif
            end else if (step_s) begin
                trial_r <= trial_nx_s;
                idx_r   <= finish_s ? IDX_ZERO : (idx_r - IDX_ONE);
            end
            if (finish_s) begin
                code_r   <= trial_nx_s;
                ch_out_r <= ch_r;
`ifdef SAR_ADC_OVR_EN
                ovr_r    <= ovr_smp_r;
`endif
            end
            busy_r  <= (state_nx_s == ST_SAMPLE) || (state_nx_s == ST_CONVERT);
            valid_r <= (state_nx_s == ST_DONE);
            dac_r   <= (state_nx_s == ST_CONVERT) ? real'(trial_nx_s) * LSB : 0.0;
        end
    end

    assign bus.busy   = busy_r;
    assign bus.valid  = valid_r;
    assign bus.code   = code_r;
    assign bus.ch_out = ch_out_r;
    assign dac_level  = dac_r;
`ifdef SAR_ADC_OVR_EN
    assign bus.ovr    = ovr_r;
`endif
endmodule

// File: tb/tb_sar_adc_mc.sv
// Directed + randomized bench for sar_adc_mc against a floor/clamp reference model.
module tb_sar_adc_mc;
    localparam int  BITS     = 8;
    localparam int  CHANNELS = 4;
    localparam real VREF     = 1.0;

    logic       clk = 1'b0;
    logic       rst;
    real        vin [CHANNELS];
    real        dac_level;
    int         pass_cnt  = 0;
    int         total_cnt = 0;
    logic [7:0] last_code;
    logic [1:0] last_ch;
    int         exp_v;
    int         bad;

    sar_adc_mc_if #(.BITS(BITS), .CHANNELS(CHANNELS)) bus ();

    sar_adc_mc #(.BITS(BITS), .CHANNELS(CHANNELS), .VREF(VREF)) dut (
        .clk       (clk),
        .rst       (rst),
        .vin       (vin),
        .dac_level (dac_level),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // Ideal quantiser: clamp to [0, VREF], then floor(v / LSB), saturated at full scale
    function automatic int ref_code(input real v);
        real h;
        int  e;
        h = (v < 0.0) ? 0.0 : ((v > VREF) ? VREF : v);
        e = int'($floor(h * real'(1 << BITS) / VREF));
        if (e > (1 << BITS) - 1) e = (1 << BITS) - 1;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total_cnt++;
        assert (obs === expv) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete conversion launched in the current cycle (cycle 0); result expected in cycle 10
    task automatic run_conv(input logic [1:0] ch, input real v, input logic ab0, input string tag);
        int e;
        int early;
        vin[ch]    = v;
        bus.ch_sel = ch;
        bus.start  = 1'b1;
        bus.abort  = ab0;
        e          = ref_code(v);
        early      = 0;
        for (int c = 1; c <= 9; c++) begin
            step();
            bus.start = 1'b0;
            bus.abort = 1'b0;
            if (bus.valid) early++;
            if (c == 1) chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
            if (c == 2) chk({tag, "_dac_msb"}, 32'(dac_level == VREF / 2.0), 32'd1);
        end
        step();
        chk({tag, "_early_valid"}, 32'(early), 32'd0);
        chk({tag, "_valid"}, 32'(bus.valid), 32'd1);
        chk({tag, "_code"}, 32'(bus.code), 32'(e));
        chk({tag, "_ch"}, 32'(bus.ch_out), 32'(ch));
`ifdef SAR_ADC_OVR_EN
        chk({tag, "_ovr"}, 32'(bus.ovr), 32'((v < 0.0) || (v > VREF)));
`endif
        step();
        chk({tag, "_valid_off"}, 32'(bus.valid), 32'd0);
        chk({tag, "_dac_idle"}, 32'(dac_level == 0.0), 32'd1);
        last_code = 8'(e);
        last_ch   = ch;
    endtask

    initial begin
        rst        = 1'b0;
        bus.start  = 1'b0;
        bus.abort  = 1'b0;
        bus.ch_sel = 2'd0;
        for (int i = 0; i < CHANNELS; i++) vin[i] = 0.0;
        step();
        step();
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_valid", 32'(bus.valid), 32'd0);
        chk("rst_code", 32'(bus.code), 32'd0);
        chk("rst_ch", 32'(bus.ch_out), 32'd0);
        chk("rst_dac", 32'(dac_level == 0.0), 32'd1);
        rst = 1'b1;

        run_conv(2'd0, 0.5, 1'b0, "mid");
        run_conv(2'd2, 1.0, 1'b0, "full");
        run_conv(2'd1, -0.3, 1'b0, "neg");
        run_conv(2'd3, 0.0039, 1'b0, "lsb_below");
        run_conv(2'd3, 0.0040, 1'b0, "lsb_above");
        run_conv(2'd2, 1.25, 1'b0, "over");
        run_conv(2'd1, 0.6, 1'b1, "idle_abort");
        for (int k = 0; k < 16; k++) begin
            run_conv(2'($urandom_range(0, CHANNELS - 1)),
                     real'($urandom_range(0, 14000)) / 10000.0 - 0.2, 1'b0, "rand");
        end

        // Second start while converting is ignored
        vin[0] = 0.25; vin[2] = 1.0;
        bus.ch_sel = 2'd0; bus.start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            step();
            bus.start = (c == 3);
            bus.ch_sel = (c == 3) ? 2'd2 : 2'd0;
        end
        chk("ign_valid", 32'(bus.valid), 32'd1);
        chk("ign_code", 32'(bus.code), 32'(ref_code(0.25)));
        chk("ign_ch", 32'(bus.ch_out), 32'd0);
        last_code = bus.code;
        last_ch   = 2'd0;
        step();

        // Abort in CONVERT discards the result
        vin[1] = 0.7; bus.ch_sel = 2'd1; bus.start = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            step();
            bus.start = (c == 3);
            bus.ch_sel = (c == 3) ? 2'd2 : 2'd1;
            bus.abort = (c == 5);
        end
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_dac", 32'(dac_level == 0.0), 32'd1);
        bad = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            if (bus.valid) bad++;
        end
        chk("abort_no_valid", 32'(bad), 32'd0);
        chk("abort_code_kept", 32'(bus.code), 32'(last_code));
        chk("abort_ch_kept", 32'(bus.ch_out), 32'(last_ch));

        // Back-to-back with start held high, then reset mid-conversion
        vin[0] = 0.25; bus.ch_sel = 2'd0; bus.start = 1'b1;
        exp_v = ref_code(0.25);
        bad = 0;
        for (int c = 1; c <= 34; c++) begin
            step();
            if (c % 10 == 0) begin
                chk("b2b_valid", 32'(bus.valid), 32'd1);
                chk("b2b_code", 32'(bus.code), 32'(exp_v));
            end else if (bus.valid) begin
                bad++;
            end
        end
        chk("b2b_stray_valid", 32'(bad), 32'd0);
        chk("b2b_busy_before_rst", 32'(bus.busy), 32'd1);
        rst = 1'b0;
        #1;
        chk("arst_busy", 32'(bus.busy), 32'd0);
        chk("arst_valid", 32'(bus.valid), 32'd0);
        chk("arst_code", 32'(bus.code), 32'd0);
        chk("arst_ch", 32'(bus.ch_out), 32'd0);
        chk("arst_dac", 32'(dac_level == 0.0), 32'd1);
        step();
        step();
        bus.start = 1'b0;
        rst = 1'b1;
        bad = 0;
        for (int c = 0; c < 15; c++) begin
            step();
            if (bus.valid || bus.busy) bad++;
        end
        chk("post_rst_quiet", 32'(bad), 32'd0);
        run_conv(2'd3, 0.8, 1'b0, "recover");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
